uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Parametrised, single-clock, memory-mapped UART transmitter. Successor to the fixed 32-bit word-to-byte UART output path.
- CPU stores go into a FIFO. Each entry is either a full data word, sent as bytes MSB-first, or a single byte.
- Entries are serialised as UART frames: start, 8 data bits LSB-first, optional parity, 1 stop.
- Adds a readable status register, a sticky overflow flag, a programmable bit period and back-to-back frames with no idle gap.

Parameters:
- DATA_W, 32: store data width; must be a multiple of 8. BYTES_PER_WORD = DATA_W/8.
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW entries.
- CLKS_PER_BIT, 868: clk cycles per serial bit (100 MHz / 115200); must be >= 2.
- BASE_ADDR, 32'h0000_7000: base of the register window.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- we  in  1  store strobe, one cycle per store
- address  in  32  byte address of the store or read
- dataIn  in  DATA_W  store data
- readData  out  32  combinational read of the register at address
- serial  out  1  UART TX line, idles high
- fifo_full  out  1  FIFO holds 2**FIFO_AW entries
- tx_idle  out  1  FIFO empty, no word pending and no frame in progress

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset. All state is updated on the rising edge of clk.
- Register map:
  - BASE+0x0 TXWORD (write): push {mode=word, dataIn}.
  - BASE+0x4 TXBYTE (write): push {mode=byte, dataIn}; only dataIn[7:0] is transmitted.
  - BASE+0x8 STATUS (read/write): reads {16'b0, level[7:0], 4'b0, overflow, tx_active, full, empty}. Any write clears overflow.
  - Other addresses: writes are ignored; readData = 0.
- FIFO:
  - Entries are DATA_W+1 bits wide.
  - A push while full is dropped and sets overflow (sticky). This holds even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle when not full: level is unchanged.
  - level counts 0..2**FIFO_AW.
- Byte sequencer:
  - Holds one popped entry (word_reg) and a byte index.
  - Pops when word_reg is empty and the FIFO is non-empty.
  - Word mode emits bytes [DATA_W-1:DATA_W-8] first, down to [7:0]. Byte mode emits one byte.
  - word_reg empties after its last byte is handed to the transmitter.
- TX FSM: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE, or STOP -> START if a byte is pending.
  - Each state lasts exactly CLKS_PER_BIT cycles; DATA lasts 8 x CLKS_PER_BIT.
  - The bit counter and baud counter reset on every state entry.
  - Back-to-back frames: the next START begins the cycle after the STOP period ends, with no idle cycles.
- Latency: a TXWORD/TXBYTE write accepted at edge E into an idle block drives serial low starting at edge E+3 (E+1 pop, E+2 byte load, E+3 START).
- Frame lengths:
  - Frame = 10 x CLKS_PER_BIT cycles, or 11 with parity.
  - Word = BYTES_PER_WORD frames, contiguous.
- tx_active = word_reg non-empty OR FSM != IDLE.
- tx_idle = empty AND !tx_active.
- Reset values, applied on the next edge even mid-frame:
  - serial = 1, FSM = IDLE, FIFO level = 0, word_reg empty, overflow = 0.
  - fifo_full = 0, tx_idle = 1.
  - A partially sent frame is abandoned.

Optional Feature:
- Macro: UART_TX_MMIO_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame = 11 bits.
  - STATUS bit 4 reads 1, identifying the build.
- Undefined:
  - No PARITY state; frame = 10 bits.
  - STATUS bit 4 reads 0.

Test Plan (CLKS_PER_BIT=4, DATA_W=32, FIFO_AW=4, macro undefined):
- Reset held 3 cycles then released -> serial=1, tx_idle=1, fifo_full=0, STATUS read = 32'h0000_0001.
- Write 32'hA5C3_0F81 to 0x7000 at edge E -> serial low from E+3. Bytes A5, C3, 0F, 81 are sent as 160 contiguous cycles; the A5 data bits are 1,0,1,0,0,1,0,1. tx_idle=1 at E+163.
- Write 32'h1234_5655 to 0x7004 -> a single 40-cycle frame with data 0x55. Bytes 12, 34, 56 are never sent.
- 20 back-to-back TXWORD writes while idle -> 17 accepted, 3 dropped. fifo_full=1, STATUS = level 16, overflow=1. Writing 0x7008 clears overflow only; all 17 words are then sent in order.
- Assert reset in the middle of the second byte's DATA state -> next edge: serial=1, level=0, tx_idle=1. No further frames appear.
- With UART_TX_MMIO_PARITY_EN defined: TXBYTE 0x07 -> 44-cycle frame with parity bit 1. TXBYTE 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
//   Memory-mapped UART transmitter. CPU stores land in a FIFO as either a
//   full data word (sent as bytes, most significant byte first) or a single
//   byte. Each byte is sent as one UART frame: start bit, 8 data bits
//   LSB-first, optional even parity bit, one stop bit. Consecutive frames
//   run back to back with no idle gap between them.
//
//   Build option: define UART_TX_MMIO_PARITY_EN to insert an even-parity
//   bit after the data bits. In that build STATUS bit 4 reads 1.
//
//   Ports
//     clk        system clock, rising edge
//     reset      synchronous, active-high reset
//     we         store strobe, one cycle per store
//     address    byte address of the store or read
//     dataIn     store data
//     readData   combinational read of the register at address
//     serial     UART TX line, idles high
//     fifo_full  FIFO holds 2**FIFO_AW entries
//     tx_idle    FIFO empty and nothing pending or in flight
//
//   Register map (offsets from BASE_ADDR)
//     0x0 TXWORD  write: queue dataIn as a word
//     0x4 TXBYTE  write: queue dataIn[7:0] as a single byte
//     0x8 STATUS  read : {16'b0, level[7:0], 3'b0, parity_build,
//                         overflow, tx_active, full, empty}
//                 write: clears overflow
//
//   state  | meaning
//   IDLE   | line high, waiting for a pending byte
//   START  | start bit (low)
//   DATA   | 8 data bits, LSB first
//   PARITY | even parity bit (parity build only)
//   STOP   | stop bit (high); chains straight into START if a byte waits

module uart_tx_mmio #(
    parameter int          DATA_W       = 32,
    parameter int          FIFO_AW      = 4,
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_7000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] dataIn,
    output logic [31:0]       readData,
    output logic              serial,
    output logic              fifo_full,
    output logic              tx_idle
);

    localparam int BPW   = DATA_W / 8;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_MMIO_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    localparam logic PARITY_EN = 1'b0;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // ---------------- register decode ----------------
    logic w_wr_word, w_wr_byte, w_wr_status, w_push_req;
    assign w_wr_word   = we && (address == BASE_ADDR);
    assign w_wr_byte   = we && (address == BASE_ADDR + 32'h4);
    assign w_wr_status = we && (address == BASE_ADDR + 32'h8);
    assign w_push_req  = w_wr_word || w_wr_byte;

    // ---------------- FIFO ----------------
    // Entry layout: {is_byte, data}
    logic [DATA_W:0]    r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic               r_overflow;
    logic               w_empty, w_full, w_push, w_pop;
    logic [DATA_W:0]    w_head;

    logic               r_word_vld;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == (FIFO_AW+1)'(DEPTH));
    // A store that meets a full FIFO is dropped even if a pop frees a slot
    // on the same edge.
    assign w_push  = w_push_req && !w_full;
    assign w_pop   = !r_word_vld && !w_empty;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_wr_byte, dataIn};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
            if (w_wr_status)                r_overflow <= 1'b0;
            else if (w_push_req && w_full)  r_overflow <= 1'b1;
        end
    end

    // ---------------- byte sequencer ----------------
    // word_reg holds one popped entry; bytes are handed one at a time into a
    // single pending-byte slot that the transmitter drains.
    logic [DATA_W-1:0] r_word_data;
    logic              r_word_is_byte;
    logic [IDX_W-1:0]  r_idx;
    logic              r_pend_vld;
    logic [7:0]        r_pend_byte;
    logic              w_handoff, w_last, w_take;
    logic [7:0]        w_cur_byte;

    assign w_handoff  = r_word_vld && !r_pend_vld;
    assign w_last     = r_word_is_byte || (r_idx == '0);
    assign w_cur_byte = r_word_is_byte ? r_word_data[7:0]
                                       : 8'(r_word_data >> {r_idx, 3'b000});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_vld     <= 1'b0;
            r_word_data    <= '0;
            r_word_is_byte <= 1'b0;
            r_idx          <= '0;
            r_pend_vld     <= 1'b0;
            r_pend_byte    <= '0;
        end else begin
            if (w_pop) begin
                r_word_vld     <= 1'b1;
                r_word_data    <= w_head[DATA_W-1:0];
                r_word_is_byte <= w_head[DATA_W];
                r_idx          <= IDX_W'(BPW - 1);
            end else if (w_handoff) begin
                if (w_last) r_word_vld <= 1'b0;
                else        r_idx      <= r_idx - 1'b1;
            end
            if (w_handoff) begin
                r_pend_vld  <= 1'b1;
                r_pend_byte <= w_cur_byte;
            end else if (w_take) begin
                r_pend_vld  <= 1'b0;
            end
        end
    end

    // ---------------- TX FSM ----------------
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_baud;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_par;
    logic             w_bit_end;

    assign w_bit_end = (r_baud == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_vld) begin
                    w_state_nxt = S_START;
                    w_take      = 1'b1;
                end
            end
            S_START: if (w_bit_end) w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_bit_end && (r_bit == 3'd7)) begin
`ifdef UART_TX_MMIO_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_TX_MMIO_PARITY_EN
            S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_pend_vld) begin
                        w_state_nxt = S_START;
                        w_take      = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= BAUD_RELOAD;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Baud counter is held at reload while idle, so every state entry
            // starts a fresh full bit period.
            if (r_state == S_IDLE || w_bit_end) r_baud <= BAUD_RELOAD;
            else                                r_baud <= r_baud - 1'b1;
            if (w_state_nxt != r_state)             r_bit <= '0;
            else if (r_state == S_DATA && w_bit_end) r_bit <= r_bit + 1'b1;
            if (w_take) begin
                r_shift <= r_pend_byte;
                r_par   <= ^r_pend_byte;
            end else if (r_state == S_DATA && w_bit_end) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

    always_comb begin
        serial = 1'b1;
        case (r_state)
            S_START:  serial = 1'b0;
            S_DATA:   serial = r_shift[0];
`ifdef UART_TX_MMIO_PARITY_EN
            S_PARITY: serial = r_par;
`endif
            default:  serial = 1'b1;
        endcase
    end

    // ---------------- status / outputs ----------------
    logic       w_tx_active;
    logic [7:0] w_level8;

    // The pending-byte slot counts as part of word_reg for activity.
    assign w_tx_active = r_word_vld || r_pend_vld || (r_state != S_IDLE);
    assign w_level8    = 8'(r_level);
    assign fifo_full   = w_full;
    assign tx_idle     = w_empty && !w_tx_active;

    always_comb begin
        readData = '0;
        if (address == BASE_ADDR + 32'h8) begin
            readData = {16'b0, w_level8, 3'b0, PARITY_EN,
                        r_overflow, w_tx_active, w_full, w_empty};
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h0000_7000;
`ifdef UART_TX_MMIO_PARITY_EN
    localparam int          NBITS = 11;
    localparam logic [31:0] ST_ID = 32'h10;
`else
    localparam int          NBITS = 10;
    localparam logic [31:0] ST_ID = 32'h0;
`endif
    localparam int FR = NBITS * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] dataIn = '0;
    logic [31:0] readData;
    logic        serial, fifo_full, tx_idle;

    uart_tx_mmio #(
        .DATA_W(32), .FIFO_AW(4), .CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .we(we), .address(address), .dataIn(dataIn),
        .readData(readData), .serial(serial), .fifo_full(fifo_full), .tx_idle(tx_idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int rst_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (reset) rst_cnt <= rst_cnt + 1;

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] q_exp[$];
    int         q_starts[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference model: a word store yields its bytes MSB first, a byte store
    // yields its low byte, anything else yields nothing.
    task automatic model_store(input logic [31:0] a, input logic [31:0] d);
        if (a == BASE) begin
            for (int i = 3; i >= 0; i--) q_exp.push_back(8'(d >> (8 * i)));
        end else if (a == BASE + 32'h4) begin
            q_exp.push_back(d[7:0]);
        end
    endtask

    // Called at a negedge; returns the index of the edge that took the store.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, output int e);
        we = 1'b1; address = a; dataIn = d;
        @(posedge clk); #1;
        e = cyc;
        @(negedge clk);
        we = 1'b0; address = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readData;
        address = '0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(tx_idle === 1'b1 && q_exp.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    // Monitor: decodes frames off the line and compares against the queue.
    initial begin : monitor
        int s, rc;
        logic [7:0] b, e;
        logic sb, pb, stp;
        forever begin
            @(negedge clk);
            if (!reset && serial === 1'b0) begin
                s  = cyc;
                rc = rst_cnt;
                q_starts.push_back(s);
                repeat (CPB / 2) @(negedge clk);
                sb = serial;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = serial;
                end
                pb = 1'b0;
`ifdef UART_TX_MMIO_PARITY_EN
                repeat (CPB) @(negedge clk);
                pb = serial;
`endif
                repeat (CPB) @(negedge clk);
                stp = serial;
                if (rst_cnt == rc) begin
                    chk("start_bit", 32'(sb), 32'd0);
                    chk("stop_bit", 32'(stp), 32'd1);
                    if (q_exp.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_frame: got byte %h expected none", b);
                    end else begin
                        e = q_exp.pop_front();
                        chk("frame_byte", 32'(b), 32'(e));
`ifdef UART_TX_MMIO_PARITY_EN
                        chk("parity_bit", 32'(pb), 32'(^e));
`endif
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int e, n0, k, kind, gap;
        logic [31:0] v, d, a;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_serial", 32'(serial), 32'd1);
        chk("rst_tx_idle", 32'(tx_idle), 32'd1);
        chk("rst_fifo_full", 32'(fifo_full), 32'd0);
        rd(BASE + 32'h8, v);
        chk("rst_status", v, 32'h1 | ST_ID);
        @(negedge clk);

        // Word store: latency, contiguity, idle timing
        n0 = q_starts.size();
        wr(BASE, 32'hA5C3_0F81, e);
        model_store(BASE, 32'hA5C3_0F81);
        while (cyc < e + 2 + 4 * FR) @(negedge clk);
        chk("word_busy_last", 32'(tx_idle), 32'd0);
        @(negedge clk);
        chk("word_idle", 32'(tx_idle), 32'd1);
        chk("word_latency", 32'(q_starts[n0]), 32'(e + 3));
        for (int i = 1; i < 4; i++)
            chk("word_gap", 32'(q_starts[n0+i] - q_starts[n0+i-1]), 32'(FR));
        chk("word_all_sent", 32'(q_exp.size()), 32'd0);

        // Byte store: only the low byte, one frame
        n0 = q_starts.size();
        wr(BASE + 32'h4, 32'h1234_5655, e);
        model_store(BASE + 32'h4, 32'h1234_5655);
        while (cyc < e + 2 + FR) @(negedge clk);
        chk("byte_busy_last", 32'(tx_idle), 32'd0);
        @(negedge clk);
        chk("byte_idle", 32'(tx_idle), 32'd1);
        chk("byte_latency", 32'(q_starts[n0]), 32'(e + 3));
        chk("byte_frames", 32'(q_starts.size() - n0), 32'd1);
        chk("byte_all_sent", 32'(q_exp.size()), 32'd0);

`ifdef UART_TX_MMIO_PARITY_EN
        wr(BASE + 32'h4, 32'h07, e);
        model_store(BASE + 32'h4, 32'h07);
        wait_idle("par07_drain", 3 * FR);
        wr(BASE + 32'h4, 32'h03, e);
        model_store(BASE + 32'h4, 32'h03);
        wait_idle("par03_drain", 3 * FR);
`endif

        // Burst of 20 word stores from idle: one goes straight into the
        // transmit path, 16 fill the FIFO, 3 are dropped.
        n0 = q_starts.size();
        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            wr(BASE, d, e);
            if (i < 17) model_store(BASE, d);
        end
        chk("burst_full", 32'(fifo_full), 32'd1);
        rd(BASE + 32'h8, v);
        chk("burst_status", v, 32'h0000_100E | ST_ID);
        @(negedge clk);
        wr(BASE + 32'h8, $urandom, e);
        chk("clr_full_kept", 32'(fifo_full), 32'd1);
        rd(BASE + 32'h8, v);
        chk("clr_status", v, 32'h0000_1006 | ST_ID);
        @(negedge clk);
        wait_idle("burst_drain", 17 * 4 * FR + 100);
        chk("burst_frames", 32'(q_starts.size() - n0), 32'd68);

        // Reset in the middle of the second byte's data bits
        d = $urandom;
        wr(BASE, d, e);
        model_store(BASE, d);
        while (cyc < e + 3 + FR + CPB + 10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q_exp.delete();
        chk("mid_rst_serial", 32'(serial), 32'd1);
        chk("mid_rst_tx_idle", 32'(tx_idle), 32'd1);
        rd(BASE + 32'h8, v);
        chk("mid_rst_status", v, 32'h1 | ST_ID);
        @(negedge clk);
        n0 = q_starts.size();
        repeat (300) @(negedge clk);
        chk("mid_rst_no_frames", 32'(q_starts.size() - n0), 32'd0);

        // Randomized rounds
        for (int r = 0; r < 30; r++) begin
            k = $urandom_range(1, 6);
            for (int j = 0; j < k; j++) begin
                kind = $urandom_range(0, 3);
                d = $urandom;
                case (kind)
                    0: a = BASE;
                    1: a = BASE + 32'h4;
                    2: a = ($urandom_range(0, 1) == 0) ? (BASE + 32'h10 + 32'($urandom_range(0, 15) << 2))
                                                      : (BASE ^ 32'h0001_0000);
                    default: a = BASE + 32'h8;
                endcase
                wr(a, d, e);
                model_store(a, d);
                gap = $urandom_range(0, 3);
                repeat (gap) @(negedge clk);
            end
            wait_idle("rand_drain", 6 * 4 * FR + 100);
        end
        rd(BASE + 32'h8, v);
        chk("final_status", v, 32'h1 | ST_ID);
        rd(BASE + 32'h0C, v);
        chk("read_other", v, 32'h0);
        rd(BASE, v);
        chk("read_txword", v, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
